// File: rtl/irq_pending_ctrl.sv
// Request stage ahead of the 8-bit priority encoder: edge capture, pending/mask, and a held-index handshake.
// Define IRQ_SYNC_EN to pass irq_in through a 2-flop synchronizer (adds 2 cycles of latency).
module irq_pending_ctrl #(
   parameter int TIMEOUT = 255,
   parameter int TO_W    = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] irq_in,
   input  logic [7:0] mask,
   input  logic       irq_ack,
   output logic [7:0] eligible,
   output logic       irq_out,
   output logic [2:0] irq_id,
   output logic       timeout
);

   typedef enum logic {IDLE, ACTIVE} state_t;

   state_t            state, state_d;
   logic [7:0]        irq_s;
   logic [7:0]        irq_prev;
   logic [7:0]        pending;
   logic [7:0]        pending_next;
   logic [7:0]        rise;
   logic [7:0]        clr;
   logic              irq_out_d;
   logic [2:0]        irq_id_d;
   logic              timeout_d;
   logic [TO_W-1:0]   counter, counter_d;

`ifdef IRQ_SYNC_EN
   logic [7:0] sync1, sync2;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= irq_in;
         sync2 <= sync1;
      end
   end

   assign irq_s = sync2;
`else
   assign irq_s = irq_in;
`endif

   function automatic logic [2:0] top_index(input logic [7:0] v);
      top_index = 3'd0;
      for (int i = 0; i < 8; i++)
         if (v[i]) top_index = 3'(i);
   endfunction

   // A fresh edge on the bit being acknowledged wins over its clear.
   always_comb begin
      rise         = irq_s & ~irq_prev;
      clr          = (state == ACTIVE && irq_ack) ? (8'b1 << irq_id) : 8'b0;
      pending_next = (pending & ~clr) | rise;
   end

   // eligible follows pending one cycle behind, but drops an acked bit at once so IDLE never re-grants it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         irq_prev <= '0;
         pending  <= '0;
         eligible <= '0;
      end else begin
         irq_prev <= irq_s;
         pending  <= pending_next;
         eligible <= pending & ~clr & ~mask;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         irq_out <= 1'b0;
         irq_id  <= 3'd0;
         timeout <= 1'b0;
         counter <= '0;
      end else begin
         state   <= state_d;
         irq_out <= irq_out_d;
         irq_id  <= irq_id_d;
         timeout <= timeout_d;
         counter <= counter_d;
      end
   end

   // Grant from IDLE, then hold irq_id until ack or timeout.
   always_comb begin
      state_d   = state;
      irq_out_d = irq_out;
      irq_id_d  = irq_id;
      timeout_d = 1'b0;
      counter_d = counter;
      case (state)
         IDLE: begin
            if (eligible != 8'b0) begin
               irq_id_d  = top_index(eligible);
               irq_out_d = 1'b1;
               counter_d = '0;
               state_d   = ACTIVE;
            end
         end
         ACTIVE: begin
            if (irq_ack) begin
               irq_out_d = 1'b0;
               state_d   = IDLE;
            end else if (TIMEOUT != 0 && counter == TO_W'(TIMEOUT - 1)) begin
               irq_out_d = 1'b0;
               timeout_d = 1'b1;
               state_d   = IDLE;
            end else begin
               counter_d = counter + TO_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Directed bench for irq_pending_ctrl (default build, TIMEOUT=4): vector table plus multi-cycle sequences.
module tb_irq_pending_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] irq_in;
   logic [7:0] mask;
   logic       irq_ack;
   logic [7:0] eligible;
   logic       irq_out;
   logic [2:0] irq_id;
   logic       timeout;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [7:0] in;
      logic [7:0] msk;
      logic       ack;
      logic [7:0] e_elig;
      logic       e_out;
      logic [2:0] e_id;
      logic       e_to;
      string      name;
   } vec_t;

   vec_t vecs[18];

   irq_pending_ctrl #(.TIMEOUT(4), .TO_W(8)) dut (
      .clk      (clk),
      .rst      (rst),
      .irq_in   (irq_in),
      .mask     (mask),
      .irq_ack  (irq_ack),
      .eligible (eligible),
      .irq_out  (irq_out),
      .irq_id   (irq_id),
      .timeout  (timeout)
   );

   always #5 clk = ~clk;

   task applyStimulus(input logic [7:0] i, input logic [7:0] m, input logic a);
      irq_in  = i;
      mask    = m;
      irq_ack = a;
      @(posedge clk);
      #1;
   endtask

   task checkOutput(input string name, input logic [7:0] ee, input logic eo,
                    input logic [2:0] ei, input logic et);
      checks++;
      if (eligible !== ee || irq_out !== eo || irq_id !== ei || timeout !== et) begin
         failures++;
         $display("[TB] FAIL %s: got eligible=%h irq_out=%b irq_id=%0d timeout=%b, expected eligible=%h irq_out=%b irq_id=%0d timeout=%b",
                  name, eligible, irq_out, irq_id, timeout, ee, eo, ei, et);
      end
   endtask

   initial begin
      // single pulse on bit 2
      vecs[0]  = '{8'h04, 8'h00, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, "t1_capture"};
      vecs[1]  = '{8'h00, 8'h00, 1'b0, 8'h04, 1'b0, 3'd0, 1'b0, "t1_eligible"};
      vecs[2]  = '{8'h00, 8'h00, 1'b0, 8'h04, 1'b1, 3'd2, 1'b0, "t1_grant"};
      vecs[3]  = '{8'h00, 8'h00, 1'b1, 8'h00, 1'b0, 3'd2, 1'b0, "t1_ack"};
      vecs[4]  = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 3'd2, 1'b0, "t1_idle"};
      // bits 7 and 0 together
      vecs[5]  = '{8'h81, 8'h00, 1'b0, 8'h00, 1'b0, 3'd2, 1'b0, "t2_capture"};
      vecs[6]  = '{8'h81, 8'h00, 1'b0, 8'h81, 1'b0, 3'd2, 1'b0, "t2_eligible"};
      vecs[7]  = '{8'h81, 8'h00, 1'b0, 8'h81, 1'b1, 3'd7, 1'b0, "t2_grant7"};
      vecs[8]  = '{8'h81, 8'h00, 1'b1, 8'h01, 1'b0, 3'd7, 1'b0, "t2_ack7"};
      vecs[9]  = '{8'h81, 8'h00, 1'b0, 8'h01, 1'b1, 3'd0, 1'b0, "t2_grant0"};
      vecs[10] = '{8'h81, 8'h00, 1'b1, 8'h00, 1'b0, 3'd0, 1'b0, "t2_ack0"};
      vecs[11] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, "t2_empty"};
      // masked bit 5, released later
      vecs[12] = '{8'h20, 8'h20, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, "t4_masked_capture"};
      vecs[13] = '{8'h00, 8'h20, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, "t4_masked_hold1"};
      vecs[14] = '{8'h00, 8'h20, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, "t4_masked_hold2"};
      vecs[15] = '{8'h00, 8'h00, 1'b0, 8'h20, 1'b0, 3'd0, 1'b0, "t4_unmask"};
      vecs[16] = '{8'h00, 8'h00, 1'b0, 8'h20, 1'b1, 3'd5, 1'b0, "t4_grant5"};
      vecs[17] = '{8'h00, 8'h00, 1'b1, 8'h00, 1'b0, 3'd5, 1'b0, "t4_ack5"};

      irq_in  = 8'h00;
      mask    = 8'h00;
      irq_ack = 1'b0;
      rst     = 1'b0;
      #1 rst  = 1'b1;
      #11;
      checkOutput("reset_state", 8'h00, 1'b0, 3'd0, 1'b0);
      @(negedge clk);
      rst = 1'b0;

      foreach (vecs[k]) begin
         applyStimulus(vecs[k].in, vecs[k].msk, vecs[k].ack);
         checkOutput(vecs[k].name, vecs[k].e_elig, vecs[k].e_out, vecs[k].e_id, vecs[k].e_to);
      end

      // higher-priority arrival while bit 3 is in service
      applyStimulus(8'h08, 8'h00, 1'b0);
      applyStimulus(8'h00, 8'h00, 1'b0);
      applyStimulus(8'h00, 8'h00, 1'b0);
      checkOutput("t3_grant3", 8'h08, 1'b1, 3'd3, 1'b0);
      applyStimulus(8'h40, 8'h00, 1'b0);
      checkOutput("t3_hold_a", 8'h08, 1'b1, 3'd3, 1'b0);
      applyStimulus(8'h00, 8'h00, 1'b0);
      checkOutput("t3_hold_b", 8'h48, 1'b1, 3'd3, 1'b0);
      applyStimulus(8'h00, 8'h00, 1'b0);
      checkOutput("t3_hold_c", 8'h48, 1'b1, 3'd3, 1'b0);
      applyStimulus(8'h00, 8'h00, 1'b1);
      checkOutput("t3_ack3", 8'h40, 1'b0, 3'd3, 1'b0);
      applyStimulus(8'h00, 8'h00, 1'b0);
      checkOutput("t3_grant6", 8'h40, 1'b1, 3'd6, 1'b0);
      applyStimulus(8'h00, 8'h00, 1'b1);
      checkOutput("t3_ack6", 8'h00, 1'b0, 3'd6, 1'b0);

      // bit 1 never acked: 4 cycles high, timeout pulse, re-grant
      applyStimulus(8'h02, 8'h00, 1'b0);
      applyStimulus(8'h00, 8'h00, 1'b0);
      applyStimulus(8'h00, 8'h00, 1'b0);
      checkOutput("t5_grant1", 8'h02, 1'b1, 3'd1, 1'b0);
      for (int c = 1; c < 4; c++) begin
         applyStimulus(8'h00, 8'h00, 1'b0);
         checkOutput($sformatf("t5_high_%0d", c), 8'h02, 1'b1, 3'd1, 1'b0);
      end
      applyStimulus(8'h00, 8'h00, 1'b0);
      checkOutput("t5_timeout", 8'h02, 1'b0, 3'd1, 1'b1);
      applyStimulus(8'h00, 8'h00, 1'b0);
      checkOutput("t5_regrant", 8'h02, 1'b1, 3'd1, 1'b0);
      applyStimulus(8'h00, 8'h00, 1'b1);
      checkOutput("t5_ack", 8'h00, 1'b0, 3'd1, 1'b0);

      // new edge on bit 0 during its own ack cycle keeps it pending
      applyStimulus(8'h01, 8'h00, 1'b0);
      applyStimulus(8'h00, 8'h00, 1'b0);
      applyStimulus(8'h00, 8'h00, 1'b0);
      checkOutput("t6_grant0", 8'h01, 1'b1, 3'd0, 1'b0);
      applyStimulus(8'h01, 8'h00, 1'b1);
      checkOutput("t6_ack_with_edge", 8'h00, 1'b0, 3'd0, 1'b0);
      applyStimulus(8'h01, 8'h00, 1'b0);
      checkOutput("t6_still_pending", 8'h01, 1'b0, 3'd0, 1'b0);
      applyStimulus(8'h00, 8'h00, 1'b0);
      checkOutput("t6_regrant0", 8'h01, 1'b1, 3'd0, 1'b0);
      applyStimulus(8'h00, 8'h00, 1'b1);
      checkOutput("t6_ack", 8'h00, 1'b0, 3'd0, 1'b0);

      // asynchronous reset while bit 4 is in service and bit 5 is waiting
      applyStimulus(8'h10, 8'h00, 1'b0);
      applyStimulus(8'h00, 8'h00, 1'b0);
      applyStimulus(8'h00, 8'h00, 1'b0);
      checkOutput("t7_grant4", 8'h10, 1'b1, 3'd4, 1'b0);
      applyStimulus(8'h20, 8'h00, 1'b0);
      irq_in = 8'h00;
      #2 rst = 1'b1;
      #1;
      checkOutput("t7_async_reset", 8'h00, 1'b0, 3'd0, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
         applyStimulus(8'h00, 8'h00, 1'b0);
         checkOutput($sformatf("t7_after_release_%0d", c), 8'h00, 1'b0, 3'd0, 1'b0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
